// File: rtl/term_pkg.sv
// Shared constants, FSM state encoding and byte classification for the
// text-terminal write controller.
package term_pkg;
  localparam int TERM_COLS = 32;
  localparam int TERM_ROWS = 4;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE, S_PUT, S_MOVE, S_BACK, S_ECHO, S_CLEAR
  } term_state_t;

  typedef enum logic [1:0] {C_NONE, C_PRINT, C_NL, C_BS} ch_class_t;

  function automatic ch_class_t classify(input logic [7:0] b);
    ch_class_t c;
    c = C_NONE;
    if (b >= PRINT_LO && b <= PRINT_HI) c = C_PRINT;
    else if (b == CH_CR || b == CH_LF)  c = C_NL;
    else if (b == CH_BS)                c = C_BS;
    return c;
  endfunction
endpackage

// File: rtl/term_cursor.sv
// Logical cursor (col 0..31, row 0..3) with advance/newline/back/home and the
// rotated logical->physical column mapping used by the RAM and display.
module term_cursor
  import term_pkg::*;
#(
  parameter int COL_OFFSET = 24,
  parameter int HOME_ROW   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  logic       newline,
  input  logic       back,
  input  logic       home,
  output logic [4:0] phys_x,
  output logic [1:0] row
);
  logic [4:0] col;

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= HOME_ROW[1:0];
    end else if (home) begin
      col <= '0;
      row <= HOME_ROW[1:0];
    end else if (newline) begin
      col <= '0;
      row <= row + 2'd1;
    end else if (adv) begin
      col <= col + 5'd1;
      if (col == 5'(TERM_COLS - 1)) row <= row + 2'd1;
    end else if (back) begin
      if (col != 5'd0) col <= col - 5'd1;
    end
  end

  // 5-bit add wraps mod 32 for free
  assign phys_x = col + COL_OFFSET[4:0];
endmodule

// File: rtl/term_write_ctrl.sv
// Turns UART bytes and clear requests into character-RAM write cycles,
// owns the cursor and schedules the byte echo back to the UART.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COL_OFFSET = 24,
  parameter int HOME_ROW   = 1,
  parameter int ECHO_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clr_req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       ram_we,
  output logic [1:0] ram_wy,
  output logic [4:0] ram_wx,
  output logic [7:0] ram_wdata,
  output logic [4:0] cur_x,
  output logic [1:0] cur_y,
  output logic       busy,
  output logic       overflow
);
  term_state_t state, nxt;
  logic [7:0]  ch, buf_data, src;
  logic        buf_full, clr_pend, src_valid, start_clr, ld_ch;
  logic [6:0]  n;
  logic        adv, nl, back, home;

  term_cursor #(.COL_OFFSET(COL_OFFSET), .HOME_ROW(HOME_ROW)) u_cursor (
    .clk(clk), .reset(reset), .adv(adv), .newline(nl), .back(back),
    .home(home), .phys_x(cur_x), .row(cur_y)
  );

  // a held byte always goes ahead of a fresh one
  assign src_valid = buf_full | rx_valid;
  assign src       = buf_full ? buf_data : rx_data;
  assign start_clr = (state == S_IDLE) && (clr_req || clr_pend);
  assign busy      = (state != S_IDLE);
  assign tx_data   = ch;

  always_comb begin
    nxt       = state;
    ram_we    = 1'b0;
    ram_wy    = '0;
    ram_wx    = '0;
    ram_wdata = '0;
    tx_start  = 1'b0;
    adv       = 1'b0;
    nl        = 1'b0;
    back      = 1'b0;
    home      = 1'b0;
    ld_ch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_clr) nxt = S_CLEAR;
        else if (src_valid) begin
          ld_ch = 1'b1;
          case (classify(src))
            C_PRINT: nxt = S_PUT;
            C_NL:    nxt = S_MOVE;
            C_BS:    nxt = S_BACK;
            default: nxt = S_IDLE;
          endcase
        end
      end
      S_PUT: begin
        ram_we    = 1'b1;
        ram_wy    = cur_y;
        ram_wx    = cur_x;
        ram_wdata = (ch == CH_BS) ? CH_SPACE : ch;
        nxt       = (ch == CH_BS) ? S_ECHO : S_MOVE;
      end
      S_MOVE: begin
        if (classify(ch) == C_NL) nl = 1'b1;
        else                      adv = 1'b1;
        nxt = S_ECHO;
      end
      S_BACK: begin
        back = 1'b1;
        nxt  = S_PUT;
      end
      S_ECHO: begin
        if (ECHO_EN == 0) nxt = S_IDLE;
        else if (!tx_busy) begin
          tx_start = 1'b1;
          nxt      = S_IDLE;
        end
      end
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_wy    = n[6:5];
        ram_wx    = n[4:0];
        ram_wdata = CH_SPACE;
        if (n == 7'(TERM_COLS * TERM_ROWS - 1)) begin
          home = 1'b1;
          nxt  = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ch       <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      clr_pend <= 1'b0;
      n        <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      if (ld_ch) ch <= src;
      if (state == S_IDLE) begin
        if (start_clr) begin
          // clear wins: held byte and same-cycle byte are both discarded
          buf_full <= 1'b0;
          clr_pend <= 1'b0;
          n        <= '0;
        end else if (buf_full) begin
          buf_full <= rx_valid;
          if (rx_valid) buf_data <= rx_data;
        end
      end else begin
        if (rx_valid) begin
          if (buf_full) overflow <= 1'b1;
          else begin
            buf_full <= 1'b1;
            buf_data <= rx_data;
          end
        end
        if (clr_req && state != S_CLEAR) clr_pend <= 1'b1;
        if (state == S_CLEAR) n <= n + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed bench for term_write_ctrl: hand-computed cursor/write/echo results
// observed through a negedge bus monitor.
module tb_term_write_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, clr_req = 1'b0, tx_busy = 1'b0;
  logic       tx_start, ram_we, busy, overflow;
  logic [7:0] tx_data, ram_wdata;
  logic [1:0] ram_wy, cur_y;
  logic [4:0] ram_wx, cur_x;

  term_write_ctrl #(.COL_OFFSET(24), .HOME_ROW(1), .ECHO_EN(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .clr_req(clr_req), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .ram_we(ram_we), .ram_wy(ram_wy), .ram_wx(ram_wx),
    .ram_wdata(ram_wdata), .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int we_cnt = 0, tx_cnt = 0, nsp_cnt = 0, viol = 0;
  int sp_cnt [128];
  int sp_base [128];
  logic [1:0] l_wy;
  logic [4:0] l_wx;
  logic [7:0] l_wd, l_tx;

  initial for (int i = 0; i < 128; i++) sp_cnt[i] = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      l_wy = ram_wy; l_wx = ram_wx; l_wd = ram_wdata;
      if (ram_wdata == 8'h20) sp_cnt[{ram_wy, ram_wx}]++;
      else nsp_cnt++;
    end
    if (tx_start) begin
      tx_cnt++;
      l_tx = tx_data;
      if (tx_busy) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  // idle must hold two samples: IDLE lasts one cycle when a held byte is pending
  task automatic wait_idle(input int budget, input string tag);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 2; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 2) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic put(input logic [7:0] b);
    send(b);
    wait_idle(50, "put");
  endtask

  int we0, tx0, nsp0, cov;

  initial begin
    do_reset();
    // reset state
    chk("rst_x", 32'(cur_x), 32'd24);
    chk("rst_y", 32'(cur_y), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_txs", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_wd", 32'({ram_wy, ram_wx, ram_wdata}), 32'd0);

    // single 'A' with exact latency
    we0 = we_cnt; tx0 = tx_cnt;
    @(negedge clk); rx_data = 8'h41; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    chk("a_put_t1", 32'(ram_we), 32'd1);
    chk("a_put_loc", 32'({ram_wy, ram_wx, ram_wdata}), 32'({2'd1, 5'd24, 8'h41}));
    @(negedge clk);
    chk("a_move_t2", 32'(ram_we), 32'd0);
    chk("a_x_t2", 32'(cur_x), 32'd24);
    @(negedge clk);
    chk("a_x_t3", 32'(cur_x), 32'd25);
    chk("a_txs_t3", 32'(tx_start), 32'd1);
    wait_idle(20, "a");
    chk("a_we_n", 32'(we_cnt - we0), 32'd1);
    chk("a_tx_n", 32'(tx_cnt - tx0), 32'd1);
    chk("a_tx_d", 32'(l_tx), 32'h41);
    chk("a_y", 32'(cur_y), 32'd1);

    // 32 printables wrap to next row
    do_reset();
    for (int i = 0; i < 32; i++) put(8'h61 + 8'(i % 26));
    chk("w32_last", 32'({l_wy, l_wx}), 32'({2'd1, 5'd23}));
    chk("w32_cur", 32'({cur_y, cur_x}), 32'({2'd2, 5'd24}));
    put(8'h0A); put(8'h31); put(8'h32);
    chk("pre_cr", 32'({cur_y, cur_x}), 32'({2'd3, 5'd26}));
    we0 = we_cnt;
    put(8'h0D);
    chk("cr_nowr", 32'(we_cnt - we0), 32'd0);
    chk("cr_cur", 32'({cur_y, cur_x}), 32'({2'd0, 5'd24}));
    chk("cr_echo", 32'(l_tx), 32'h0D);
    we0 = we_cnt;
    put(8'h07);
    chk("ign_wr", 32'(we_cnt - we0), 32'd0);
    chk("ign_echo", 32'(l_tx), 32'h0D);

    // backspace at col 0 and mid-line
    do_reset();
    we0 = we_cnt;
    put(8'h08);
    chk("bs0_wr", 32'({l_wy, l_wx, l_wd}), 32'({2'd1, 5'd24, 8'h20}));
    chk("bs0_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd24}));
    chk("bs0_echo", 32'(l_tx), 32'h08);
    put(8'h58); put(8'h59);
    put(8'h08);
    chk("bs_wr", 32'({l_wy, l_wx, l_wd}), 32'({2'd1, 5'd25, 8'h20}));
    chk("bs_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd25}));
    chk("bs_wcnt", 32'(we_cnt - we0), 32'd4);

    // full clear with a byte arriving mid-sweep
    put(8'h0D);
    we0 = we_cnt;
    for (int i = 0; i < 128; i++) sp_base[i] = sp_cnt[i];
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    send(8'h42);
    wait_idle(400, "clr");
    cov = 0;
    for (int i = 0; i < 128; i++) if (sp_cnt[i] > sp_base[i]) cov++;
    chk("clr_cov", 32'(cov), 32'd128);
    chk("clr_wcnt", 32'(we_cnt - we0), 32'd129);
    chk("clr_b", 32'({l_wy, l_wx, l_wd}), 32'({2'd1, 5'd24, 8'h42}));
    chk("clr_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd25}));

    // echo stall: one in flight, one held, one dropped
    do_reset();
    chk("ovf_clr", 32'(overflow), 32'd0);
    we0 = we_cnt; tx0 = tx_cnt;
    tx_busy = 1'b1;
    @(negedge clk); rx_data = 8'h31; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h32;
    @(negedge clk); rx_data = 8'h33;
    @(negedge clk); rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_tx", 32'(tx_cnt - tx0), 32'd0);
    chk("stall_ovf", 32'(overflow), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    wait_idle(50, "stall");
    chk("stall_tx2", 32'(tx_cnt - tx0), 32'd2);
    chk("stall_we2", 32'(we_cnt - we0), 32'd2);
    chk("stall_last", 32'(l_tx), 32'h32);
    chk("stall_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd26}));
    chk("txs_vs_busy", 32'(viol), 32'd0);

    // clear beats same-cycle byte
    we0 = we_cnt; tx0 = tx_cnt; nsp0 = nsp_cnt;
    @(negedge clk); clr_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk); clr_req = 1'b0; rx_valid = 1'b0;
    wait_idle(400, "clrrx");
    chk("clrrx_we", 32'(we_cnt - we0), 32'd128);
    chk("clrrx_tx", 32'(tx_cnt - tx0), 32'd0);
    chk("clrrx_nsp", 32'(nsp_cnt - nsp0), 32'd0);
    chk("clrrx_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd24}));

    // reset in the middle of a clear
    put(8'h5A);
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstclr_we", 32'(ram_we), 32'd0);
    chk("rstclr_cur", 32'({cur_y, cur_x}), 32'({2'd1, 5'd24}));
    chk("rstclr_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    we0 = we_cnt;
    repeat (10) @(negedge clk);
    chk("rstclr_quiet", 32'(we_cnt - we0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
